// File: rtl/pe_pkg.sv
// Shared encodings and types for the multi-cycle CGRA processing element.
// Used by pe_alu and pe_multicycle.
package pe_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;
    localparam logic [2:0] F3_W   = 3'b010;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    typedef struct packed {
        alu_op_e   op;
        imm_type_e itype;
        logic      use_imm;
        logic      is_load;
        logic      is_store;
        logic      is_branch;
        logic      is_jal;
        logic      wr_rd;
        logic      illegal;
    } dec_t;

    // 32-bit immediate; callers sign-extend to XLEN.
    function automatic logic [31:0] imm32(input logic [31:0] i,
                                          input imm_type_e t);
        logic [31:0] r;
        r = '0;
        case (t)
            IMM_I:   r = {{20{i[31]}}, i[31:20]};
            IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25],
                          i[11:8], 1'b0};
            IMM_U:   r = {i[31:12], 12'b0};
            IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20],
                          i[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pe_alu.sv
// Combinational XLEN-wide ALU for the processing element.
// MUL is only implemented when PE_MUL_EN is defined.
module pe_alu
    import pe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e           op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   y_o
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];

    always_comb begin
        y_o = '0;
        unique case (op_i)
            ALU_ADD:   y_o = a_i + b_i;
            ALU_SUB:   y_o = a_i - b_i;
            ALU_SLL:   y_o = a_i << shamt;
            ALU_SLT:   y_o[0] = $signed(a_i) < $signed(b_i);
            ALU_XOR:   y_o = a_i ^ b_i;
            ALU_SRL:   y_o = a_i >> shamt;
            ALU_SRA:   y_o = $signed(a_i) >>> shamt;
            ALU_OR:    y_o = a_i | b_i;
            ALU_AND:   y_o = a_i & b_i;
`ifdef PE_MUL_EN
            ALU_MUL:   y_o = a_i * b_i;
`endif
            ALU_PASSB: y_o = b_i;
            default:   y_o = '0;
        endcase
    end

endmodule

// File: rtl/pe_multicycle.sv
// Multi-cycle RV32I-subset processing element: IDLE/DECODE/EXEC/MEM/WB.
// Define PE_MUL_EN to decode OP funct7=0000001 funct3=000 as MUL.
module pe_multicycle
    import pe_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [XLEN-1:0] PCin,
    input  logic [31:0]     instruction,
    output logic [4:0]      rs1Out,
    output logic [4:0]      rs2Out,
    input  logic [XLEN-1:0] AmuxIn,
    input  logic [XLEN-1:0] BmuxIn,
    output logic [4:0]      rdOut,
    output logic            rdWrite,
    output logic [XLEN-1:0] result_out,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] messReg,
    input  logic            mem_ack,
    input  logic            data_Ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] PCout,
    output logic            pc_valid,
    output logic            err
);

    state_e          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    dec_t            dec_q, dec_d, dec_c;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] pcout_q, pcout_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            abort_q, abort_d;
    logic            err_q, err_d;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            sh_ok;
    logic [XLEN-1:0] imm_x;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] pc_plus4;
    logic            taken;

    assign opc   = instr_q[6:0];
    assign f3    = instr_q[14:12];
    assign f7    = instr_q[31:25];
    // bit 25 is part of the shift amount only on 64-bit datapaths
    assign sh_ok = (XLEN == 64) || !instr_q[25];

    always_comb begin
        dec_c       = '0;
        dec_c.op    = ALU_ADD;
        dec_c.itype = IMM_NONE;
        case (opc)
            OPC_LUI: begin
                dec_c.itype   = IMM_U;
                dec_c.use_imm = 1'b1;
                dec_c.op      = ALU_PASSB;
                dec_c.wr_rd   = 1'b1;
            end
            OPC_JAL: begin
                dec_c.itype  = IMM_J;
                dec_c.is_jal = 1'b1;
                dec_c.wr_rd  = 1'b1;
            end
            OPC_BRANCH: begin
                dec_c.itype     = IMM_B;
                dec_c.is_branch = 1'b1;
                dec_c.illegal   = !(f3 == F3_BEQ || f3 == F3_BNE ||
                                    f3 == F3_BLT || f3 == F3_BGE);
            end
            OPC_LOAD: begin
                dec_c.itype   = IMM_I;
                dec_c.is_load = 1'b1;
                dec_c.wr_rd   = 1'b1;
                dec_c.illegal = (f3 != F3_W);
            end
            OPC_STORE: begin
                dec_c.itype    = IMM_S;
                dec_c.is_store = 1'b1;
                dec_c.illegal  = (f3 != F3_W);
            end
            OPC_OPIMM: begin
                dec_c.itype   = IMM_I;
                dec_c.use_imm = 1'b1;
                dec_c.wr_rd   = 1'b1;
                case (f3)
                    F3_ADD: dec_c.op = ALU_ADD;
                    F3_SLT: dec_c.op = ALU_SLT;
                    F3_XOR: dec_c.op = ALU_XOR;
                    F3_OR:  dec_c.op = ALU_OR;
                    F3_AND: dec_c.op = ALU_AND;
                    F3_SLL: begin
                        dec_c.op      = ALU_SLL;
                        dec_c.illegal = !(sh_ok &&
                                          instr_q[31:26] == 6'b0);
                    end
                    F3_SR: begin
                        dec_c.op      = instr_q[30] ? ALU_SRA
                                                    : ALU_SRL;
                        dec_c.illegal = !(sh_ok &&
                            (instr_q[31:26] == 6'b000000 ||
                             instr_q[31:26] == 6'b010000));
                    end
                    default: dec_c.illegal = 1'b1;
                endcase
            end
            OPC_OP: begin
                dec_c.wr_rd = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  dec_c.op = ALU_ADD;
                        F3_SLL:  dec_c.op = ALU_SLL;
                        F3_SLT:  dec_c.op = ALU_SLT;
                        F3_XOR:  dec_c.op = ALU_XOR;
                        F3_SR:   dec_c.op = ALU_SRL;
                        F3_OR:   dec_c.op = ALU_OR;
                        F3_AND:  dec_c.op = ALU_AND;
                        default: dec_c.illegal = 1'b1;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    dec_c.op = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == F3_SR) begin
                    dec_c.op = ALU_SRA;
`ifdef PE_MUL_EN
                end else if (f7 == F7_MULDIV && f3 == F3_ADD) begin
                    dec_c.op = ALU_MUL;
`endif
                end else begin
                    dec_c.illegal = 1'b1;
                end
            end
            default: dec_c.illegal = 1'b1;
        endcase
    end

    assign imm_x    = XLEN'($signed(imm32(instr_q, dec_q.itype)));
    assign alu_b    = dec_q.use_imm ? imm_x : BmuxIn;
    assign pc_plus4 = pc_q + XLEN'(4);

    pe_alu #(.XLEN(XLEN)) u_alu (
        .op_i (dec_q.op),
        .a_i  (AmuxIn),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    always_comb begin
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = (AmuxIn == BmuxIn);
            F3_BNE:  taken = (AmuxIn != BmuxIn);
            F3_BLT:  taken = $signed(AmuxIn) < $signed(BmuxIn);
            F3_BGE:  taken = $signed(AmuxIn) >= $signed(BmuxIn);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        dec_d    = dec_q;
        result_d = result_q;
        pcout_d  = pcout_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instruction;
                    pc_d    = PCin;
                    abort_d = 1'b0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                dec_d   = dec_c;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                cnt_d = '0;
                if (dec_q.illegal) begin
                    err_d   = 1'b1;
                    pcout_d = pc_plus4;
                    state_d = S_WB;
                end else begin
                    result_d = dec_q.is_jal ? pc_plus4 : alu_y;
                    addr_d   = AmuxIn + imm_x;
                    wdata_d  = BmuxIn;
                    pcout_d  = (dec_q.is_jal ||
                                (dec_q.is_branch && taken))
                             ? pc_q + imm_x : pc_plus4;
                    state_d  = (dec_q.is_load || dec_q.is_store)
                             ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                // completion has priority over a coincident timeout
                if (dec_q.is_load && data_Ready) begin
                    result_d = mem_rdata;
                    state_d  = S_WB;
                end else if (dec_q.is_store && mem_ack) begin
                    state_d = S_WB;
                end else if (cnt_q + 8'd1 == 8'(MEM_TIMEOUT)) begin
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            pc_q     <= '0;
            dec_q    <= '0;
            result_q <= '0;
            pcout_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            dec_q    <= dec_d;
            result_q <= result_d;
            pcout_q  <= pcout_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE) && !rst;
    assign rs1Out      = instr_q[19:15];
    assign rs2Out      = instr_q[24:20];
    assign rdOut       = instr_q[11:7];
    assign rdWrite     = (state_q == S_WB) && dec_q.wr_rd &&
                         !dec_q.illegal && !abort_q &&
                         (instr_q[11:7] != 5'd0);
    assign result_out  = result_q;
    assign mem_read    = (state_q == S_MEM) && dec_q.is_load;
    assign mem_write   = (state_q == S_MEM) && dec_q.is_store;
    assign mem_address = addr_q;
    assign messReg     = wdata_q;
    assign PCout       = pcout_q;
    assign pc_valid    = (state_q == S_WB);
    assign err         = err_q;

endmodule

// File: tb/tb_pe_multicycle.sv
// Scoreboard bench for pe_multicycle: directed vectors, WB and memory
// monitors pop expectations queued by the driver.
module tb_pe_multicycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] PCin = '0;
    logic [31:0] instruction = '0;
    logic [4:0]  rs1Out, rs2Out, rdOut;
    logic [31:0] AmuxIn = '0;
    logic [31:0] BmuxIn = '0;
    logic        rdWrite;
    logic [31:0] result_out;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, messReg;
    logic        mem_ack = 1'b0;
    logic        data_Ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] PCout;
    logic        pc_valid;
    logic        err;

    always #5 clk = ~clk;

    pe_multicycle #(.XLEN(32), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .PCin(PCin), .instruction(instruction),
        .rs1Out(rs1Out), .rs2Out(rs2Out),
        .AmuxIn(AmuxIn), .BmuxIn(BmuxIn),
        .rdOut(rdOut), .rdWrite(rdWrite), .result_out(result_out),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .messReg(messReg),
        .mem_ack(mem_ack), .data_Ready(data_Ready),
        .mem_rdata(mem_rdata),
        .PCout(PCout), .pc_valid(pc_valid), .err(err)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] pc;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          len;
    } mexp_t;

    exp_t  wbq[$];
    mexp_t memq[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    resp_lat = 0;
    logic [31:0] rdata_v = '0;
    bit    mute = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %08h required %08h", nm, act, req);
        end
    endtask

    // memory responder: answers on the resp_lat-th MEM cycle (0 = never)
    int mcnt = 0;
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            mcnt = mcnt + 1;
            if (resp_lat != 0 && mcnt == resp_lat) begin
                data_Ready = mem_read;
                mem_ack    = mem_write;
                mem_rdata  = rdata_v;
            end else begin
                data_Ready = 1'b0;
                mem_ack    = 1'b0;
            end
        end else begin
            mcnt       = 0;
            data_Ready = 1'b0;
            mem_ack    = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && pc_valid) begin
            if (mute) begin
                chk("wb_after_rst", {31'b0, pc_valid}, 32'd0);
            end else if (wbq.size() == 0) begin
                chk("wb_unexpected", {31'b0, pc_valid}, 32'd0);
            end else begin
                e = wbq.pop_front();
                chk("wb_latency", cyc - e.acc, e.lat);
                chk("pcout", PCout, e.pc);
                chk("rdwrite", {31'b0, rdWrite}, {31'b0, e.wr});
                chk("err", {31'b0, err}, {31'b0, e.err});
                if (e.wr) begin
                    chk("rdout", {27'b0, rdOut}, {27'b0, e.rd});
                    chk("result", result_out, e.res);
                end
            end
        end
    end

    bit          m_act = 1'b0;
    logic        m_wr;
    logic [31:0] m_addr, m_data;
    int          m_len = 0;
    always @(negedge clk) begin
        mexp_t m;
        if (mem_read || mem_write) begin
            if (!m_act) begin
                m_act  = 1'b1;
                m_len  = 0;
                m_wr   = mem_write;
                m_addr = mem_address;
                m_data = messReg;
            end
            m_len = m_len + 1;
        end else if (m_act) begin
            m_act = 1'b0;
            if (!mute) begin
                if (memq.size() == 0) begin
                    chk("mem_unexpected", 32'd1, 32'd0);
                end else begin
                    m = memq.pop_front();
                    chk("mem_write", {31'b0, m_wr}, {31'b0, m.wr});
                    chk("mem_addr", m_addr, m.addr);
                    chk("mem_cycles", m_len, m.len);
                    if (m.wr) chk("mem_data", m_data, m.data);
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!instr_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // mk: 0 no memory access, 1 load, 2 store
    task automatic vec(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b,
                       input int lat_r, input logic [31:0] rdat,
                       input logic wr, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] pcx,
                       input logic errx, input int wlat,
                       input int mk, input logic [31:0] maddr,
                       input logic [31:0] mdata, input int mlen);
        exp_t  e;
        mexp_t m;
        wait_ready();
        resp_lat = lat_r;
        rdata_v  = rdat;
        e.wr = wr; e.rd = rd; e.res = res; e.pc = pcx;
        e.err = errx; e.lat = wlat; e.acc = cyc;
        wbq.push_back(e);
        if (mk != 0) begin
            m.wr = (mk == 2); m.addr = maddr;
            m.data = mdata; m.len = mlen;
            memq.push_back(m);
        end
        instruction = ins;
        PCin        = pc;
        AmuxIn      = a;
        BmuxIn      = b;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual hang required finish");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, instr_ready}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_pcvalid", {31'b0, pc_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, instr_ready}, 32'd1);
        chk("rst_pcout", PCout, 32'd0);
        chk("rst_result", result_out, 32'd0);

        // ADDI x1,x0,5
        vec(32'h00500093, 32'h100, 0, 0, 0, 0,
            1, 1, 32'd5, 32'h104, 0, 3, 0, 0, 0, 0);
        // ADD x3,x1,x2 wraps
        vec(32'h002081B3, 32'h104, 32'hFFFFFFFF, 1, 0, 0,
            1, 3, 32'd0, 32'h108, 0, 3, 0, 0, 0, 0);
        // LW x5,8(x2), data on 2nd MEM cycle
        vec(32'h00812283, 32'h108, 32'h1000, 0, 2, 32'hDEADBEEF,
            1, 5, 32'hDEADBEEF, 32'h10C, 0, 5, 1, 32'h1008, 0, 2);
        // SRAI x6,x1,4
        vec(32'h4040D313, 32'h10C, 32'h80000000, 0, 0, 0,
            1, 6, 32'hF8000000, 32'h110, 0, 3, 0, 0, 0, 0);
        // JAL x1,+8
        vec(32'h008000EF, 32'h500, 0, 0, 0, 0,
            1, 1, 32'h504, 32'h508, 0, 3, 0, 0, 0, 0);
        // BEQ taken / not taken
        vec(32'h00208863, 32'h200, 7, 7, 0, 0,
            0, 0, 0, 32'h210, 0, 3, 0, 0, 0, 0);
        vec(32'h00208863, 32'h200, 7, 8, 0, 0,
            0, 0, 0, 32'h204, 0, 3, 0, 0, 0, 0);
        // SW ack coincides with timeout: completion wins
        vec(32'h00312223, 32'h300, 32'h2000, 32'h12345678, 15, 0,
            0, 0, 0, 32'h304, 0, 18, 2, 32'h2004, 32'h12345678, 15);
`ifdef PE_MUL_EN
        vec(32'h02208233, 32'h380, 6, 7, 0, 0,
            1, 4, 32'd42, 32'h384, 0, 3, 0, 0, 0, 0);
`else
        vec(32'h02208233, 32'h380, 6, 7, 0, 0,
            0, 0, 0, 32'h384, 1, 3, 0, 0, 0, 0);
`endif
        // SW x3,4(x2) with no ack: timeout abort
        vec(32'h00312223, 32'h400, 32'h2000, 32'hCAFEF00D, 0, 0,
            0, 0, 0, 32'h404, 1, 18, 2, 32'h2004, 32'hCAFEF00D, 15);
        // all-ones word is illegal
        vec(32'hFFFFFFFF, 32'h600, 0, 0, 0, 0,
            0, 0, 0, 32'h604, 1, 3, 0, 0, 0, 0);

        t = 0;
        while ((wbq.size() != 0 || memq.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", wbq.size() + memq.size(), 32'd0);

        rst = 1'b1;
        @(negedge clk);
        chk("err_cleared", {31'b0, err}, 32'd0);
        chk("ready_in_rst", {31'b0, instr_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_again", {31'b0, instr_ready}, 32'd1);

        // reset while a load is stuck in MEM
        mute = 1'b1;
        resp_lat = 0;
        wait_ready();
        instruction = 32'h00812283;
        AmuxIn = 32'h1000;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        t = 0;
        while (!mem_read && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("midop_memread", {31'b0, mem_read}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midop_memread_off", {31'b0, mem_read}, 32'd0);
        chk("midop_pcvalid", {31'b0, pc_valid}, 32'd0);
        chk("midop_rdwrite", {31'b0, rdWrite}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        mute = 1'b0;
        chk("midop_idle", {31'b0, instr_ready}, 32'd1);
        chk("midop_err", {31'b0, err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
